// File: rtl/lap_pkg.sv
// Shared definitions for the Laplacian frame path: default frame geometry,
// reader FSM states and the stream beat carried between stages.
package lap_pkg;

   localparam int LAP_ROWS   = 242;
   localparam int LAP_COLS   = 247;
   localparam int LAP_PIX_W  = 8;
   localparam int LAP_ADDR_W = 16;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [LAP_PIX_W-1:0] data;
      logic                 sof;
      logic                 eol;
      logic                 eof;
   } beat_t;

endpackage

// File: rtl/lap_frame_reader_if.sv
// Frame reader bus: synchronous RAM read port plus the outgoing pixel stream.
// The master side is the reader; the slave side is RAM and downstream sink.
interface lap_frame_reader_if
   import lap_pkg::*;
#(
   parameter int PIX_W  = LAP_PIX_W,
   parameter int ADDR_W = LAP_ADDR_W
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_rd_data;
   logic              pix_valid;
   logic              pix_ready;
   logic [PIX_W-1:0]  pix_data;
   logic              pix_sof;
   logic              pix_eol;
   logic              pix_eof;

   modport master (
      output mem_rd_en, mem_addr,
      input  mem_rd_data,
      output pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
      input  pix_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr,
      output mem_rd_data,
      input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
      output pix_ready
   );
endinterface

// File: rtl/lap_stream_fifo2.sv
// Two-entry stream FIFO with simultaneous push/pop; head is the oldest entry.
// The beat type is a parameter so stream stages of any pixel width can share it.
module lap_stream_fifo2
   import lap_pkg::*;
#(
   parameter type beat_T = beat_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  beat_T      push_beat_i,
   input  logic       pop_i,
   output beat_T      head_o,
   output logic [1:0] count_o
);
   beat_T      mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign do_pop  = pop_i && (count_q != 2'd0);
   assign do_push = push_i && ((count_q != 2'd2) || do_pop);

   // NOTE: state is updated with <= so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: storage is reset as well so the stream data port reads zero after reset.
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_beat_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/lap_frame_reader.sv
// Reads a ROWS x COLS frame from a synchronous RAM and streams it out in raster
// order with sof/eol/eof tags. Define LAP_READER_BORDER_ZERO_EN to zero the border.
module lap_frame_reader
   import lap_pkg::*;
#(
   parameter int ROWS   = LAP_ROWS,
   parameter int COLS   = LAP_COLS,
   parameter int PIX_W  = LAP_PIX_W,
   parameter int ADDR_W = LAP_ADDR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   lap_frame_reader_if.master bus
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   typedef struct packed {
      logic [PIX_W-1:0] data;
      logic             sof;
      logic             eol;
      logic             eof;
   } pix_beat_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } tags_t;

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              slot_q, slot_d;
   logic              zero_q, zero_d;
   tags_t             tags_q, tags_d;
   pix_beat_t         push_beat;
   pix_beat_t         head;
   logic [1:0]        count;
   logic [2:0]        committed;
   logic              pop;
   logic              issue;
   logic              is_border;
   logic              last_pix;

   // A slot may issue only if everything already owed to the FIFO still fits.
   assign pop       = (count != 2'd0) && bus.pix_ready;
   assign committed = 3'(count) + 3'(slot_q) - 3'(pop);
   assign issue     = (state_q == RUN) && (committed < 3'd2);
   assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);

`ifdef LAP_READER_BORDER_ZERO_EN
   assign is_border = (row_q == '0) || (row_q == ROW_LAST) ||
                      (col_q == '0) || (col_q == COL_LAST);
`else
   assign is_border = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path infers a latch.
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      addr_d     = addr_q;
      slot_d     = issue;
      zero_d     = is_border;
      tags_d.sof = (row_q == '0) && (col_q == '0);
      tags_d.eol = (col_q == COL_LAST);
      tags_d.eof = last_pix;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               row_d   = '0;
               col_d   = '0;
               addr_d  = '0;
            end
         end
         RUN: begin
            if (issue) begin
               if (last_pix) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     row_d = row_q + ROW_W'(1);
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
         end
         DRAIN: begin
            if (pop && head.eof) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         slot_q  <= 1'b0;
         zero_q  <= 1'b0;
         tags_q  <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         slot_q  <= slot_d;
         zero_q  <= zero_d;
         tags_q  <= tags_d;
      end
   end

   assign push_beat = {(zero_q ? {PIX_W{1'b0}} : bus.mem_rd_data),
                       tags_q.sof, tags_q.eol, tags_q.eof};

   lap_stream_fifo2 #(
      .beat_T (pix_beat_t)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (slot_q),
      .push_beat_i (push_beat),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count)
   );

   assign busy          = (state_q == RUN) || (state_q == DRAIN);
   assign done          = (state_q == DONE);
   assign bus.mem_rd_en = issue && !is_border;
   assign bus.mem_addr  = addr_q;
   assign bus.pix_valid = (count != 2'd0);
   assign bus.pix_data  = head.data;
   assign bus.pix_sof   = head.sof;
   assign bus.pix_eol   = head.eol;
   assign bus.pix_eof   = head.eof;
endmodule

// File: tb/tb_lap_frame_reader.sv
// Directed bench for lap_frame_reader on a 3x4 frame with RAM[a] = a (+100 when
// LAP_READER_BORDER_ZERO_EN is defined, where the border reads back as zero).
module tb_lap_frame_reader;
   localparam int ROWS    = 3;
   localparam int COLS    = 4;
   localparam int PIX_W   = 8;
   localparam int ADDR_W  = 16;
   localparam int N_PIX   = ROWS * COLS;
   localparam int BUDGET  = 200;
   localparam int FIRST_C = 2;
`ifdef LAP_READER_BORDER_ZERO_EN
   localparam int OFS     = 100;
   localparam int N_READS = 2;
`else
   localparam int OFS     = 0;
   localparam int N_READS = N_PIX;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic busy;
   logic done;
   int   checks = 0;
   int   errors = 0;

   lap_frame_reader_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus_if ();

   lap_frame_reader #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .PIX_W  (PIX_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (bus_if.mem_rd_en) bus_if.mem_rd_data <= 8'(int'(bus_if.mem_addr) + OFS);
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int exp_data(input int k);
      int r;
      int cc;
      r  = k / COLS;
      cc = k % COLS;
`ifdef LAP_READER_BORDER_ZERO_EN
      if (r == 0 || r == ROWS - 1 || cc == 0 || cc == COLS - 1) return 0;
`endif
      return (r * COLS + cc + OFS) % 256;
   endfunction

   function automatic int exp_rd_addr(input int n);
`ifdef LAP_READER_BORDER_ZERO_EN
      return (n == 0) ? 5 : 6;
`else
      return n;
`endif
   endfunction

   task automatic run_frame(input string name, input bit toggle, input int pre_stall,
                            input int restart_at, input int reset_at);
      logic [3:0]       tog_pat;
      logic [PIX_W-1:0] held_data;
      logic [2:0]       held_tags;
      logic [2:0]       tags;
      logic [2:0]       exp_tags;
      int c, beats, reads, eof_c, done_cnt, max_out;
      bit fin, restarted, stalled, rdy;
      tog_pat = 4'b1001;
      c = 0; beats = 0; reads = 0; eof_c = -1; done_cnt = 0; max_out = 0;
      fin = 1'b0; restarted = 1'b0; stalled = 1'b0;
      held_data = '0; held_tags = '0;
      @(negedge clk);
      start = 1'b1;
      bus_if.pix_ready = (pre_stall == 0);
      while (!fin && c < BUDGET) begin
         @(negedge clk);
         start = 1'b0;
         if (reset_at >= 0 && beats == reset_at) begin
            rst_n = 1'b0;
            #1;
            check({name, " rst busy"},  32'(busy), 0);
            check({name, " rst done"},  32'(done), 0);
            check({name, " rst rd_en"}, 32'(bus_if.mem_rd_en), 0);
            check({name, " rst addr"},  32'(bus_if.mem_addr), 0);
            check({name, " rst valid"}, 32'(bus_if.pix_valid), 0);
            check({name, " rst data"},  32'(bus_if.pix_data), 0);
            check({name, " rst tags"},  32'({bus_if.pix_sof, bus_if.pix_eol, bus_if.pix_eof}), 0);
            fin = 1'b1;
         end else begin
            if (restart_at >= 0 && beats == restart_at && !restarted) begin
               start     = 1'b1;
               restarted = 1'b1;
            end
            rdy = (c >= pre_stall) && (!toggle || tog_pat[2'(c % 4)]);
            bus_if.pix_ready = rdy;
            #1;
            tags = {bus_if.pix_sof, bus_if.pix_eol, bus_if.pix_eof};
            if (bus_if.mem_rd_en) begin
               check($sformatf("%s rd_addr %0d", name, reads), 32'(bus_if.mem_addr), 32'(exp_rd_addr(reads)));
               reads++;
            end
            if (stalled) begin
               check($sformatf("%s hold valid c%0d", name, c), 32'(bus_if.pix_valid), 1);
               check($sformatf("%s hold data c%0d", name, c), 32'(bus_if.pix_data), 32'(held_data));
               check($sformatf("%s hold tags c%0d", name, c), 32'(tags), 32'(held_tags));
            end
            if (c == pre_stall - 1) begin
               check({name, " stall valid"}, 32'(bus_if.pix_valid), 1);
               check({name, " stall data"},  32'(bus_if.pix_data), 32'(exp_data(0)));
               check({name, " stall reads<=2"}, 32'(reads <= 2), 1);
            end
            if (done) begin
               done_cnt++;
               check({name, " done timing"}, 32'(c), 32'(eof_c + 1));
            end
            if (bus_if.pix_valid && rdy) begin
               exp_tags = {beats == 0, (beats % COLS) == COLS - 1, beats == N_PIX - 1};
               check($sformatf("%s data %0d", name, beats), 32'(bus_if.pix_data), 32'(exp_data(beats)));
               check($sformatf("%s tags %0d", name, beats), 32'(tags), 32'(exp_tags));
               if (!toggle && pre_stall == 0)
                  check($sformatf("%s cycle %0d", name, beats), 32'(c), 32'(FIRST_C + beats));
               if (beats == N_PIX - 1) eof_c = c;
               beats++;
            end
            if (reads - beats > max_out) max_out = reads - beats;
            stalled   = bus_if.pix_valid && !rdy;
            held_data = bus_if.pix_data;
            held_tags = tags;
            if (eof_c >= 0 && c >= eof_c + 3) fin = 1'b1;
         end
         c++;
      end
      if (reset_at < 0) begin
         check({name, " timeout"},     32'(c < BUDGET), 1);
         check({name, " beats"},       32'(beats), 32'(N_PIX));
         check({name, " done count"},  32'(done_cnt), 1);
         check({name, " reads"},       32'(reads), 32'(N_READS));
         check({name, " outstanding"}, 32'(max_out <= 2), 1);
         check({name, " busy idle"},   32'(busy), 0);
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      start            = 1'b0;
      bus_if.pix_ready = 1'b0;
      #12;
      check("reset busy",  32'(busy), 0);
      check("reset done",  32'(done), 0);
      check("reset rd_en", 32'(bus_if.mem_rd_en), 0);
      check("reset addr",  32'(bus_if.mem_addr), 0);
      check("reset valid", 32'(bus_if.pix_valid), 0);
      check("reset data",  32'(bus_if.pix_data), 0);
      check("reset tags",  32'({bus_if.pix_sof, bus_if.pix_eol, bus_if.pix_eof}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_frame("basic",   1'b0, 0,  -1, -1);
      run_frame("toggle",  1'b1, 0,  -1, -1);
      run_frame("stall",   1'b0, 20, -1, -1);
      run_frame("restart", 1'b0, 0,   5, -1);
      run_frame("abort",   1'b0, 0,  -1,  6);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame("after_reset", 1'b0, 0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
